// File: rtl/config_load_pkg.sv
// config_load_pkg: shared FSM state type and sizing helpers for the config loader
package config_load_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;
  function automatic int wpb(input int mem_size, input int word_w);
    return mem_size / word_w;
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/config_load_ctrl_if.sv
// config_load_ctrl_if: valid/ready config word stream
interface config_load_ctrl_if #(parameter int WORD_W = 8);
  logic              cfg_valid;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_ready;
  modport master(output cfg_valid, cfg_data, input cfg_ready);
  modport slave(input cfg_valid, cfg_data, output cfg_ready);
endinterface

// File: rtl/config_word_assembler.sv
// config_word_assembler: packs WORD_W words into a MEM_SIZE image, first word in the LSBs
module config_word_assembler
  import config_load_pkg::*;
#(
  parameter int MEM_SIZE = 16,
  parameter int WORD_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                we,
  input  logic [WORD_W-1:0]   data,
  output logic                last,
  output logic [MEM_SIZE-1:0] img_next
);
  localparam int WPB = wpb(MEM_SIZE, WORD_W);
  localparam int CW  = idx_w(WPB);
  logic [CW-1:0]       cnt;
  logic [MEM_SIZE-1:0] image_q;
  assign last = cnt == CW'(WPB - 1);
  // image as it will look once the word currently offered is written
  always_comb begin
    img_next = image_q;
    img_next[cnt*WORD_W +: WORD_W] = data;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt     <= '0;
      image_q <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (we) begin
      image_q <= img_next;
      cnt     <= last ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/config_load_ctrl.sv
// config_load_ctrl: sequences word-stream loads into NUM_BLOCKS config-latch blocks
module config_load_ctrl
  import config_load_pkg::*;
#(
  parameter int MEM_SIZE   = 16,
  parameter int WORD_W     = 8,
  parameter int NUM_BLOCKS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  config_load_ctrl_if.slave              cfg,
  output logic [MEM_SIZE-1:0]            config_out,
  output logic [NUM_BLOCKS-1:0]          comb_set,
  output logic [idx_w(NUM_BLOCKS)-1:0]   blk_idx,
  output logic                           busy,
  output logic                           done
);
  localparam int IW = idx_w(NUM_BLOCKS);
  state_t              state_q, state_d;
  logic                acc, last, launch, last_blk;
  logic [MEM_SIZE-1:0] img_next;
  assign launch        = state_q == IDLE && start;
  assign acc           = cfg.cfg_valid && cfg.cfg_ready;
  assign last_blk      = blk_idx == IW'(NUM_BLOCKS - 1);
  assign cfg.cfg_ready = state_q == LOAD;
  assign busy          = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    state_d = launch                        ? LOAD :
              state_q == LOAD && acc && last ? COMMIT :
              state_q == COMMIT             ? (last_blk ? IDLE : LOAD) : state_q;
  end
  config_word_assembler #(.MEM_SIZE(MEM_SIZE), .WORD_W(WORD_W)) u_asm (
    .clk     (clk),
    .rst     (rst),
    .clr     (launch || state_q == COMMIT),
    .we      (acc),
    .data    (cfg.cfg_data),
    .last    (last),
    .img_next(img_next)
  );
  // strobe and image are registered on the COMMIT-entry edge, so both are valid throughout COMMIT
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      config_out <= '0;
      comb_set   <= '0;
      blk_idx    <= '0;
      done       <= 1'b0;
    end else begin
      state_q  <= state_d;
      comb_set <= state_d == COMMIT ? NUM_BLOCKS'(1) << blk_idx : '0;
      if (state_d == COMMIT) config_out <= img_next;
      if (launch) blk_idx <= '0;
      else if (state_q == COMMIT && !last_blk) blk_idx <= blk_idx + 1'b1;
      if (launch) done <= 1'b0;
      else if (state_q == COMMIT && last_blk) done <= 1'b1;
    end
endmodule

// File: tb/tb_config_load_ctrl.sv
// tb_config_load_ctrl: scoreboard bench for config_load_ctrl (16-bit image, 8-bit words, 4 blocks)
module tb_config_load_ctrl;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] config_out;
  logic [3:0]  comb_set;
  logic [1:0]  blk_idx;
  logic        busy, done;
  typedef struct packed {logic [1:0] b; logic [15:0] img;} exp_t;
  exp_t sb[$];
  int   n_tests = 0, n_fail = 0, done_rises = 0;
  logic done_d = 1'b0;
  config_load_ctrl_if #(.WORD_W(8)) cfg();
  config_load_ctrl #(.MEM_SIZE(16), .WORD_W(8), .NUM_BLOCKS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg(cfg),
    .config_out(config_out), .comb_set(comb_set), .blk_idx(blk_idx), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done && !done_d) done_rises++;
    done_d = done;
    if (comb_set != 4'd0) begin
      if (sb.size() == 0) check("unexpected_pulse", 32'(comb_set), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("comb_set", 32'(comb_set), 32'(4'b0001 << e.b));
        check("config_out", 32'(config_out), 32'(e.img));
        check("blk_idx_commit", 32'(blk_idx), 32'(e.b));
        check("ready_in_commit", 32'(cfg.cfg_ready), 32'd0);
      end
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d);
    int t = 0;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_data  = d;
    while (!cfg.cfg_ready && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) check("ready_timeout", 32'd0, 32'd1);
    tick();
  endtask
  task automatic gap(input int n);
    cfg.cfg_valid = 1'b0;
    cfg.cfg_data  = 8'($urandom);
    repeat (n) tick();
  endtask
  task automatic load(input logic [7:0] w[8], input int max_gap, input bit poke);
    for (int b = 0; b < 4; b++) begin
      sb.push_back({2'(b), w[2*b+1], w[2*b]});
      for (int k = 0; k < 2; k++) begin
        if (max_gap > 0) gap($urandom_range(0, max_gap));
        if (poke && b == 2 && k == 1) begin
          cfg.cfg_valid = 1'b0;
          start = 1'b1;
          tick();
          start = 1'b0;
          check("blk_after_poke", 32'(blk_idx), 32'd2);
          check("busy_after_poke", 32'(busy), 32'd1);
        end
        send(w[2*b+k]);
      end
    end
    cfg.cfg_valid = 1'b0;
  endtask
  task automatic wait_done();
    int t = 0;
    while (!done && t < 200) begin
      tick();
      t++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    logic [7:0] w3[8];
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] w3[8];
    cfg.cfg_valid = 1'b0;
    cfg.cfg_data  = 8'd0;
    #1;
    check("rst_config_out", 32'(config_out), 32'd0);
    check("rst_comb_set", 32'(comb_set), 32'd0);
    check("rst_blk_idx", 32'(blk_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(cfg.cfg_ready), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_data  = 8'hEE;
    repeat (3) tick();
    check("idle_ready", 32'(cfg.cfg_ready), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    cfg.cfg_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_busy", 32'(busy), 32'd1);
    check("load_ready", 32'(cfg.cfg_ready), 32'd1);
    sb.push_back({2'd0, 16'h1234});
    send(8'h34);
    send(8'h12);
    cfg.cfg_valid = 1'b0;
    check("commit_ready", 32'(cfg.cfg_ready), 32'd0);
    tick();
    check("n2_ready", 32'(cfg.cfg_ready), 32'd1);
    check("n2_blk_idx", 32'(blk_idx), 32'd1);
    check("n2_comb_set", 32'(comb_set), 32'd0);
    check("n2_config_out", 32'(config_out), 32'h1234);
    send(8'hAA);
    cfg.cfg_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_config_out", 32'(config_out), 32'd0);
    check("arst_blk_idx", 32'(blk_idx), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(cfg.cfg_ready), 32'd0);
    check("arst_comb_set", 32'(comb_set), 32'd0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("arst_idle", 32'(busy), 32'd0);
    check("arst_no_pending", 32'(sb.size()), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("reload_blk_idx", 32'(blk_idx), 32'd0);
    load('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 3, 1'b1);
    wait_done();
    tick();
    check("full_done", 32'(done), 32'd1);
    check("full_busy", 32'(busy), 32'd0);
    check("full_blk_idx", 32'(blk_idx), 32'd3);
    check("full_config_out", 32'(config_out), 32'h0807);
    check("full_pending", 32'(sb.size()), 32'd0);
    check("full_done_rises", 32'(done_rises), 32'd1);
    for (int i = 0; i < 8; i++) w3[i] = 8'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_done", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    load(w3, 0, 1'b0);
    wait_done();
    tick();
    check("second_done", 32'(done), 32'd1);
    check("second_config_out", 32'(config_out), 32'({w3[7], w3[6]}));
    check("second_pending", 32'(sb.size()), 32'd0);
    check("second_done_rises", 32'(done_rises), 32'd2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
